frame_padder: RTL

Output-side stage of the filter chain. Accepts the cropped interior pixel stream from a window filter, `(WIDTH-2*R_KERNEL) x (HEIGHT-2*R_KERNEL)` pixels in raster order, and re-emits a full `WIDTH x HEIGHT` raster frame. Border positions are filled with `PAD_VALUE`. The block sits after `gauss_filter`, or any later filter stage, so that every stage's output frame has the same geometry as its input. The upstream stream has no backpressure, so interior pixels are absorbed in an internal FIFO.

---
 rtl/img_pkg.sv | 16 +
 rtl/pix_fifo.sv | 54 +++++
 rtl/frame_padder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel constants, pad state type and border geometry helper
package img_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [0:0] {
    PAD_IDLE = 1'b0,
    PAD_RUN  = 1'b1
  } pad_state_e;

  // True when (x, y) lies inside the border of thickness r on a w x h frame.
  function automatic logic is_interior(input int x, input int y, input int w, input int h, input int r);
    return (x >= r) && (x < w - r) && (y >= r) && (y < h - r);
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - synchronous pixel FIFO with full/empty and same-cycle push/pop
module pix_fifo
  import img_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = PIX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_padder.sv
// rtl/frame_padder.sv - re-emits cropped interior stream as a full frame with padded border
// Optional statistics ports enabled by FRAME_PADDER_STATS_EN.
module frame_padder
  import img_pkg::*;
#(
  parameter int               WIDTH      = 512,
  parameter int               HEIGHT     = 512,
  parameter int               R_KERNEL   = 2,
  parameter logic [PIX_W-1:0] PAD_VALUE  = 8'h00,
  parameter int               FIFO_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             frame_done,
  output logic             overflow
`ifdef FRAME_PADDER_STATS_EN
  ,
  output logic [15:0]      drop_count,
  output logic [31:0]      underflow_cycles
`endif
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  pad_state_e       state;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [PIX_W-1:0] fifo_head;
  logic             run;
  logic             interior;
  logic             last_x;
  logic             last_y;
  logic             accept;
  logic             drop;

  assign run      = (state == PAD_RUN);
  assign interior = is_interior(int'(x), int'(y), WIDTH, HEIGHT, R_KERNEL);
  assign last_x   = (x == XW'(WIDTH - 1));
  assign last_y   = (y == YW'(HEIGHT - 1));

  // Interior positions wait for data; the counters simply hold while empty.
  assign out_valid = run && (!interior || !fifo_empty);
  assign out_pixel = !out_valid ? '0 : (interior ? fifo_head : PAD_VALUE);
  assign out_sof   = out_valid && (x == '0) && (y == '0);
  assign out_eol   = out_valid && last_x;

  assign accept   = out_valid && out_ready;
  assign fifo_pop = accept && interior;
  assign drop     = in_valid && fifo_full && !fifo_pop;

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_pixel),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= PAD_IDLE;
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (drop) overflow <= 1'b1;
      case (state)
        PAD_IDLE: begin
          if (in_valid) begin
            state <= PAD_RUN;
            x     <= '0;
            y     <= '0;
          end
        end
        default: begin
          if (accept) begin
            if (last_x) begin
              x <= '0;
              if (last_y) begin
                y          <= '0;
                state      <= PAD_IDLE;
                frame_done <= 1'b1;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef FRAME_PADDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count       <= '0;
      underflow_cycles <= '0;
    end else begin
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      if (run && interior && fifo_empty && (underflow_cycles != 32'hFFFF_FFFF))
        underflow_cycles <= underflow_cycles + 32'd1;
    end
  end
`endif

endmodule
